// File: rtl/adc_frame_packer_pkg.sv
// Shared widths, defaults, FSM states and buffer entry layout for the ADC frame packer.
// Pure declarations; no timing or flow control of its own.
package adc_pkg;

  localparam int ADC_W        = 12;
  localparam int FFT_W        = 16;
  localparam int DEF_FFT_LEN  = 2048;
  localparam int DEF_LOG2_LEN = 11;
  localparam int DEF_OFFSET   = 2048;

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

  typedef struct packed {
    logic [FFT_W-1:0] dat;
    logic             last;
  } buf_entry_t;

endpackage

// File: rtl/adc_frame_packer_frame_buf.sv
// Show-ahead sync FIFO of {data,last} with a registered head entry; push-to-head is 1 cycle.
// Push is refused only when full with no same-cycle pop; set_last_i marks the newest stored entry.
module frame_buf
  import adc_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       push_i,
  input  buf_entry_t push_dat_i,
  input  logic       set_last_i,
  input  logic       pop_i,
  output buf_entry_t head_dat_o,
  output logic       vld_o,
  output logic       full_o
);

  localparam int AW = $clog2(DEPTH);

  buf_entry_t    mem_q [DEPTH];
  buf_entry_t    mem_d [DEPTH];
  buf_entry_t    head_q, head_d;
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d, newest;
  logic [AW:0]   cnt_q, cnt_d;
  logic          pop, push_acc;

  assign vld_o      = (cnt_q != '0);
  assign full_o     = (cnt_q == (AW+1)'(DEPTH));
  assign pop        = pop_i && vld_o;
  assign push_acc   = push_i && (!full_o || pop);
  assign newest     = wr_q - AW'(1);
  assign head_dat_o = head_q;

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push_acc) begin
      mem_d[wr_q] = push_dat_i;
      wr_d        = wr_q + AW'(1);
    end
    if (set_last_i && !push_acc && vld_o) begin
      mem_d[newest].last = 1'b1;
    end
    if (pop) begin
      rd_d = rd_q + AW'(1);
    end
    if (push_acc && !pop) begin
      cnt_d = cnt_q + (AW+1)'(1);
    end else if (!push_acc && pop) begin
      cnt_d = cnt_q - (AW+1)'(1);
    end
    // Head register tracks the post-update memory so the output is a flop, not a read mux.
    head_d = mem_d[rd_d];
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      head_q <= '0;
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
    end else begin
      mem_q  <= mem_d;
      head_q <= head_d;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/adc_frame_packer.sv
// Frames ADC samples into FFT_LEN blocks with DC removal; in_valid to o_valid is 2 cycles.
// Input cannot stall: on a full buffer the sample is dropped, overflow is set, and the frame end is preserved.
module adc_frame_packer
  import adc_pkg::*;
#(
  parameter int FFT_LEN   = DEF_FFT_LEN,
  parameter int LOG2_LEN  = DEF_LOG2_LEN,
  parameter int DC_MODE   = 1,
  parameter int OFFSET    = DEF_OFFSET,
  parameter int BUF_DEPTH = 4
) (
  input  logic             clk_low,
  input  logic             rst,
  input  logic             en,
  input  logic [ADC_W-1:0] in_data,
  input  logic             in_valid,
  output logic [FFT_W-1:0] o_data,
  output logic             o_valid,
  output logic             o_last,
  input  logic             i_ready,
  output logic             frame_done,
  output logic             overflow,
  input  logic             ovf_clr,
  output logic [ADC_W-1:0] mean_out
);

  localparam int ACC_W = LOG2_LEN + ADC_W;

  state_e              state_q, state_d;
  logic [LOG2_LEN-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0]    acc_q, acc_d, acc_sum;
  logic [ADC_W-1:0]    mean_q, mean_d, dc;
  logic [ADC_W:0]      diff;
  buf_entry_t          s1_q, s1_d, head;
  logic                s1_vld_q, s1_vld_d;
  logic                done_q, done_d;
  logic                ovf_q, ovf_d;
  logic                capture, is_last, buf_full, drop;

  assign capture = in_valid && ((state_q == RUN) || en);
  assign is_last = capture && (cnt_q == LOG2_LEN'(FFT_LEN - 1));
  assign dc      = (DC_MODE != 0) ? mean_q : ADC_W'(OFFSET);
  assign diff    = {1'b0, in_data} - {1'b0, dc};
  assign acc_sum = acc_q + ACC_W'(in_data);
  assign drop    = s1_vld_q && buf_full && !(o_valid && i_ready);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mean_d   = mean_q;
    s1_d     = s1_q;
    s1_vld_d = 1'b0;
    done_d   = is_last;
    ovf_d    = ovf_clr ? 1'b0 : (ovf_q | drop);
    if (capture) begin
      s1_d.dat  = {{(FFT_W-ADC_W-1){diff[ADC_W]}}, diff};
      s1_d.last = is_last;
      s1_vld_d  = 1'b1;
      cnt_d     = cnt_q + LOG2_LEN'(1);
      acc_d     = acc_sum;
      state_d   = RUN;
      // Counter wraps to 0 here; en decides whether the next frame follows immediately.
      if (is_last) begin
        acc_d   = '0;
        mean_d  = ADC_W'(acc_sum >> LOG2_LEN);
        state_d = en ? RUN : IDLE;
      end
    end
  end

  always_ff @(posedge clk_low) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mean_q   <= ADC_W'(OFFSET);
      s1_q     <= '0;
      s1_vld_q <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mean_q   <= mean_d;
      s1_q     <= s1_d;
      s1_vld_q <= s1_vld_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
    end
  end

  // A dropped last sample moves its last marker onto the newest buffered entry.
  frame_buf #(
    .DEPTH(BUF_DEPTH)
  ) u_buf (
    .clk_i     (clk_low),
    .rst_ni    (rst),
    .push_i    (s1_vld_q),
    .push_dat_i(s1_q),
    .set_last_i(drop && s1_q.last),
    .pop_i     (i_ready),
    .head_dat_o(head),
    .vld_o     (o_valid),
    .full_o    (buf_full)
  );

  assign o_data     = head.dat;
  assign o_last     = head.last;
  assign frame_done = done_q;
  assign overflow   = ovf_q;
  assign mean_out   = mean_q;

endmodule

// File: tb/tb_adc_frame_packer.sv
// Directed bench for adc_frame_packer (FFT_LEN=8): two instances, previous-frame-mean and fixed-offset DC removal.
module tb_adc_frame_packer;

  logic        clk_low = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic [11:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        i_ready = 1'b1;
  logic        ovf_clr = 1'b0;

  logic [15:0] o_data, o_data0;
  logic        o_valid, o_valid0, o_last, o_last0;
  logic        frame_done, frame_done0, overflow, overflow0;
  logic [11:0] mean_out, mean_out0;

  typedef struct {
    logic [15:0] d1;
    logic [15:0] d0;
    logic        last;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;
  int   done_cnt = 0;
  int   mean_m = 2048;
  int   acc_m = 0;
  int   cnt_m = 0;
  bit   run_m = 1'b0;

  adc_frame_packer #(.FFT_LEN(8), .LOG2_LEN(3), .DC_MODE(1), .OFFSET(2048), .BUF_DEPTH(4)) u_dut (
    .clk_low(clk_low), .rst(rst), .en(en), .in_data(in_data), .in_valid(in_valid),
    .o_data(o_data), .o_valid(o_valid), .o_last(o_last), .i_ready(i_ready),
    .frame_done(frame_done), .overflow(overflow), .ovf_clr(ovf_clr), .mean_out(mean_out)
  );

  adc_frame_packer #(.FFT_LEN(8), .LOG2_LEN(3), .DC_MODE(0), .OFFSET(2048), .BUF_DEPTH(4)) u_dut0 (
    .clk_low(clk_low), .rst(rst), .en(en), .in_data(in_data), .in_valid(in_valid),
    .o_data(o_data0), .o_valid(o_valid0), .o_last(o_last0), .i_ready(i_ready),
    .frame_done(frame_done0), .overflow(overflow0), .ovf_clr(ovf_clr), .mean_out(mean_out0)
  );

  always #5 clk_low = ~clk_low;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_low);
      #1;
    end
  endtask

  // One input strobe; the expected output (if kept) goes on the scoreboard.
  task automatic strobe(input int s, input bit keep);
    exp_t e;
    exp_t t;
    in_data  = 12'(s);
    in_valid = 1'b1;
    if (run_m || en) begin
      e.d1   = 16'(s - mean_m);
      e.d0   = 16'(s - 2048);
      e.last = (cnt_m == 7);
      if (keep) begin
        q.push_back(e);
      end else if (e.last && q.size() != 0) begin
        t      = q.pop_back();
        t.last = 1'b1;
        q.push_back(t);
      end
      acc_m += s;
      if (cnt_m == 7) begin
        mean_m = acc_m / 8;
        acc_m  = 0;
        cnt_m  = 0;
        run_m  = en;
      end else begin
        cnt_m++;
        run_m = 1'b1;
      end
    end
    @(posedge clk_low);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while (q.size() != 0 && n < 64) begin
      @(posedge clk_low);
      #1;
      n++;
    end
    chk(tag, 32'(q.size()), 32'd0);
  endtask

  task automatic model_reset();
    q.delete();
    mean_m = 2048;
    acc_m  = 0;
    cnt_m  = 0;
    run_m  = 1'b0;
  endtask

  always @(negedge clk_low) begin
    if (frame_done) done_cnt++;
    if (rst && o_valid && i_ready) begin
      if (q.size() == 0) begin
        chk("spurious_out", 32'(o_valid), 32'd0);
      end else begin
        mon_e = q.pop_front();
        chk("o_data", 32'(o_data), 32'(mon_e.d1));
        chk("o_last", 32'(o_last), 32'(mon_e.last));
        chk("o_valid_dc0", 32'(o_valid0), 32'd1);
        chk("o_data_dc0", 32'(o_data0), 32'(mon_e.d0));
        chk("o_last_dc0", 32'(o_last0), 32'(mon_e.last));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk_low);
    #1;
    chk("rst_o_valid", 32'(o_valid), 32'd0);
    chk("rst_o_last", 32'(o_last), 32'd0);
    chk("rst_o_data", 32'(o_data), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_mean", 32'(mean_out), 32'd2048);
    rst = 1'b1;
    idle(2);

    // Ramp 2048..2055: outputs 0..7, 2-cycle latency, one frame_done pulse
    en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      strobe(2048 + i, 1'b1);
      if (i == 0) chk("lat_t1_no_valid", 32'(o_valid), 32'd0);
      if (i == 1) chk("lat_t2_valid", 32'(o_valid), 32'd1);
      if (i == 6) chk("done_early", 32'(frame_done), 32'd0);
    end
    chk("done_pulse", 32'(frame_done), 32'd1);
    chk("done_pulse_dc0", 32'(frame_done0), 32'd1);
    idle(1);
    chk("done_one_cycle", 32'(frame_done), 32'd0);
    wait_drain("drain_ramp");
    chk("done_cnt_ramp", 32'(done_cnt), 32'd1);
    chk("mean_ramp", 32'(mean_out), 32'd2051);
    chk("mean_ramp_dc0", 32'(mean_out0), 32'd2051);

    // Constant 1000 frames from fresh reset: -1048 then 0 with mean removal
    rst = 1'b0;
    idle(1);
    rst = 1'b1;
    model_reset();
    for (int i = 0; i < 8; i++) strobe(1000, 1'b1);
    wait_drain("drain_dc_f1");
    chk("mean_dc_f1", 32'(mean_out), 32'd1000);
    for (int i = 0; i < 8; i++) strobe(1000, 1'b1);
    wait_drain("drain_dc_f2");
    chk("mean_dc_f2", 32'(mean_out), 32'd1000);

    // Back-pressure: 6 strobes into a 4-entry buffer
    i_ready = 1'b0;
    for (int i = 0; i < 6; i++) strobe(3000 + i, i < 4);
    idle(1);
    chk("ovf_set", 32'(overflow), 32'd1);
    chk("ovf_set_dc0", 32'(overflow0), 32'd1);
    chk("stall_valid", 32'(o_valid), 32'd1);
    chk("stall_data", 32'(o_data), 32'd2000);
    idle(3);
    chk("stall_hold", 32'(o_data), 32'd2000);
    i_ready = 1'b1;
    wait_drain("drain_ovf");
    chk("ovf_sticky", 32'(overflow), 32'd1);
    strobe(3006, 1'b1);
    strobe(3007, 1'b1);
    wait_drain("drain_ovf_tail");
    ovf_clr = 1'b1;
    idle(1);
    ovf_clr = 1'b0;
    chk("ovf_clr", 32'(overflow), 32'd0);
    chk("mean_ovf_frame", 32'(mean_out), 32'd3003);

    // Dropped last sample: 4th buffered entry carries last
    i_ready = 1'b0;
    for (int i = 0; i < 8; i++) strobe(500 + i, i < 4);
    idle(2);
    chk("ovf_short", 32'(overflow), 32'd1);
    i_ready = 1'b1;
    wait_drain("drain_short");
    chk("done_cnt_short", 32'(done_cnt), 32'd5);
    ovf_clr = 1'b1;
    idle(1);
    ovf_clr = 1'b0;

    // en dropped mid-frame: frame completes, then later strobes ignored
    for (int i = 0; i < 8; i++) begin
      if (i == 3) en = 1'b0;
      strobe(700 + i, 1'b1);
    end
    wait_drain("drain_en_drop");
    chk("done_cnt_en_drop", 32'(done_cnt), 32'd6);
    for (int i = 0; i < 3; i++) strobe(900 + i, 1'b1);
    idle(4);
    chk("idle_no_out", 32'(o_valid), 32'd0);
    chk("idle_mean_hold", 32'(mean_out), 32'd703);
    chk("idle_no_done", 32'(done_cnt), 32'd6);

    // Reset mid-frame with a full buffer, then re-arm
    en = 1'b1;
    i_ready = 1'b0;
    for (int i = 0; i < 5; i++) strobe(1100 + i, i < 4);
    in_data  = 12'd1105;
    in_valid = 1'b1;
    rst      = 1'b0;
    @(posedge clk_low);
    #1;
    in_valid = 1'b0;
    chk("midrst_valid", 32'(o_valid), 32'd0);
    chk("midrst_mean", 32'(mean_out), 32'd2048);
    chk("midrst_ovf", 32'(overflow), 32'd0);
    chk("midrst_data", 32'(o_data), 32'd0);
    model_reset();
    rst = 1'b1;
    i_ready = 1'b1;
    idle(3);
    chk("midrst_empty", 32'(o_valid), 32'd0);
    for (int i = 0; i < 8; i++) strobe(1200 + i, 1'b1);
    wait_drain("drain_rearm");
    chk("mean_rearm", 32'(mean_out), 32'd1203);
    chk("done_cnt_rearm", 32'(done_cnt), 32'd7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
